// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares one 64-bit data memory between the core (C) and a DMA/debug
//            loader (D) with round-robin arbitration and a bounded DMA lock.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [63:0] c_addr,
    input  logic [63:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [63:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] LAT_INIT  = 3'(RD_LAT - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] c_rdata_q, c_rdata_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        c_rvalid_q, c_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic        w_win;
    logic        w_we;

    // Winner select: 1 = D. D may keep the bus while locked, up to MAX_BURST grants.
    always_comb begin
        w_win = d_req;
        if (c_req && d_req) begin
            if (d_lock && last_q && (burst_cnt_q < BURST_MAX)) begin
                w_win = 1'b1;
            end else begin
                w_win = ~last_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        lat_cnt_d   = lat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        addr_d      = addr_q;
        c_rdata_d   = c_rdata_q;
        d_rdata_d   = d_rdata_q;
        c_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        c_gnt       = 1'b0;
        d_gnt       = 1'b0;
        mem_addr    = 64'h0;
        mem_wdata   = 64'h0;
        mem_wr      = 1'b0;
        w_we        = w_win ? d_we : c_we;

        case (state_q)
            S_IDLE: begin
                if ((c_req || d_req) && !rst) begin
                    c_gnt       = ~w_win;
                    d_gnt       = w_win;
                    mem_addr    = w_win ? d_addr : c_addr;
                    mem_wdata   = w_win ? d_wdata : c_wdata;
                    mem_wr      = w_we;
                    last_d      = w_win;
                    burst_cnt_d = 4'h0;
                    if (w_win && c_req) begin
                        burst_cnt_d = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 4'h1 : burst_cnt_q;
                    end
                    if (!w_we) begin
                        addr_d    = w_win ? d_addr : c_addr;
                        owner_d   = w_win;
                        lat_cnt_d = LAT_INIT;
                        state_d   = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                mem_addr = addr_q;
                if (lat_cnt_q == 3'h0) begin
                    state_d = S_IDLE;
                    if (owner_q) begin
                        d_rdata_d  = mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        c_rdata_d  = mem_rdata;
                        c_rvalid_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'h1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lat_cnt_q   <= 3'h0;
            burst_cnt_q <= 4'h0;
            addr_q      <= 64'h0;
            c_rdata_q   <= 64'h0;
            d_rdata_q   <= 64'h0;
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lat_cnt_q   <= lat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            addr_q      <= addr_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
            c_rvalid_q  <= c_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign busy     = (state_q == S_RD_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Randomized scoreboard bench for dmem_arbiter against a
//            transaction-level reference model and a latency-accurate memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 4;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [63:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, busy;

    dmem_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          port;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } gnt_t;

    typedef struct {
        int          cyc;
        bit          port;
        logic [63:0] data;
    } ret_t;

    gnt_t gq[$];
    ret_t rq[$];
    gnt_t g;
    ret_t r;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    bit exp_busy = 1'b0;

    // Reference model state: transaction level, no RTL encoding.
    int          m_free  = 0;
    bit          m_last  = 1'b1;
    int          m_burst = 0;
    logic [63:0] mmem [32];

    // Stimulus state
    bit          c_pend = 1'b0, d_pend = 1'b0;
    bit          c_we_v, d_we_v;
    logic [63:0] c_addr_v, d_addr_v, c_wdata_v, d_wdata_v;
    int          c_rate, d_rate, lock_rate, we_rate;

    function automatic int midx(input logic [63:0] a);
        return int'({a[63], a[6:3]});
    endfunction

    function automatic logic [63:0] dflt(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [63:0] rnd_addr();
        logic [3:0] slot = 4'($urandom_range(0, 15));
        logic       hi   = 1'($urandom_range(0, 1));
        return {hi, 56'h0, slot, 3'b000};
    endfunction

    // Memory with exactly RD_LAT cycles from address to data.
    logic        init_mem;
    logic [63:0] phys  [32];
    logic [63:0] dpipe [RD_LAT];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) phys[i] <= dflt(i);
        end else if (mem_wr) begin
            phys[midx(mem_addr)] <= mem_wdata;
        end
        dpipe[0] <= phys[midx(mem_addr)];
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign mem_rdata = dpipe[RD_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        errs++;
        $display("FAIL %s @cyc %0d", name, cyc);
    endtask

    task automatic step(input bit gen);
        bit          win, we;
        logic [63:0] a, wd;
        @(posedge clk);
        cyc++;
        #1;
        if (gen) begin
            if (c_pend && cyc < m_free && $urandom_range(0, 19) == 0) c_pend = 1'b0;
            if (d_pend && cyc < m_free && $urandom_range(0, 19) == 0) d_pend = 1'b0;
            if (!c_pend && $urandom_range(0, 99) < c_rate) begin
                c_pend = 1'b1; c_we_v = ($urandom_range(0, 99) < we_rate);
                c_addr_v = rnd_addr(); c_wdata_v = {$urandom, $urandom};
            end
            if (!d_pend && $urandom_range(0, 99) < d_rate) begin
                d_pend = 1'b1; d_we_v = ($urandom_range(0, 99) < we_rate);
                d_addr_v = rnd_addr(); d_wdata_v = {$urandom, $urandom};
            end
            d_lock = ($urandom_range(0, 99) < lock_rate);
        end
        c_req = c_pend; c_we = c_we_v; c_addr = c_addr_v; c_wdata = c_wdata_v;
        d_req = d_pend; d_we = d_we_v; d_addr = d_addr_v; d_wdata = d_wdata_v;

        exp_busy = (cyc < m_free);
        if (!exp_busy && (c_pend || d_pend)) begin
            if (c_pend && d_pend)
                win = (d_lock && m_last && m_burst < MAX_BURST) ? 1'b1 : !m_last;
            else
                win = d_pend;
            we = win ? d_we_v : c_we_v;
            a  = win ? d_addr_v : c_addr_v;
            wd = win ? d_wdata_v : c_wdata_v;
            gq.push_back('{cyc, win, we, a, wd});
            if (win && c_pend) m_burst = (m_burst < MAX_BURST) ? m_burst + 1 : m_burst;
            else               m_burst = 0;
            m_last = win;
            if (we) begin
                mmem[midx(a)] = wd;
                m_free = cyc + 1;
            end else begin
                rq.push_back('{cyc + RD_LAT + 1, win, mmem[midx(a)]});
                m_free = cyc + RD_LAT + 1;
            end
            if (win) d_pend = 1'b0;
            else     c_pend = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        c_rate = 0; d_rate = 0;
        while ((c_pend || d_pend || cyc < m_free || rq.size() != 0) && n < 60) begin
            step(1'b1);
            n++;
        end
        if (n >= 60) fail("drain_timeout");
        step(1'b0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or read return.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            if (c_gnt && d_gnt) begin
                fail("dual_gnt");
            end else if (c_gnt || d_gnt) begin
                if (gq.size() == 0) begin
                    fail("spurious_gnt");
                end else begin
                    g = gq.pop_front();
                    chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
                    chk("gnt_port", d_gnt, g.port);
                    chk("mem_addr", mem_addr, g.addr);
                    chk("mem_wr", mem_wr, g.we);
                    if (g.we) chk("mem_wdata", mem_wdata, g.wdata);
                end
            end else begin
                chk("idle_mem_wr", mem_wr, 1'b0);
                if (gq.size() != 0 && gq[0].cyc <= cyc) begin
                    fail("missing_gnt");
                    void'(gq.pop_front());
                end
            end
            if (c_rvalid && d_rvalid) begin
                fail("dual_rvalid");
            end else if (c_rvalid || d_rvalid) begin
                if (rq.size() == 0) begin
                    fail("spurious_rvalid");
                end else begin
                    r = rq.pop_front();
                    chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    chk("rvalid_port", d_rvalid, r.port);
                    chk("rdata", d_rvalid ? d_rdata : c_rdata, r.data);
                end
            end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
                fail("missing_rvalid");
                void'(rq.pop_front());
            end
        end
    end

    int cfg [7][4] = '{
        '{100, 100,   0, 100},   // round-robin writes straight out of reset
        '{100,   0,   0, 100},   // core writes only
        '{100,   0,   0,   0},   // core reads only
        '{100, 100, 100, 100},   // locked DMA bursts
        '{ 60,  60,  50,  50},
        '{ 30,  80,  70,  30},
        '{ 90,  90,  30,  20}
    };

    initial begin
        for (int i = 0; i < 32; i++) mmem[i] = dflt(i);
        rst = 1'b1; init_mem = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 64'h10; c_wdata = 64'hDEAD;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h18; d_wdata = 64'hBEEF; d_lock = 1'b1;
        c_we_v = 1'b0; d_we_v = 1'b0; c_addr_v = '0; d_addr_v = '0; c_wdata_v = '0; d_wdata_v = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_c_gnt", c_gnt, 1'b0);
        chk("reset_d_gnt", d_gnt, 1'b0);
        chk("reset_mem_wr", mem_wr, 1'b0);
        chk("reset_mem_addr", mem_addr, 64'h0);
        chk("reset_mem_wdata", mem_wdata, 64'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_c_rvalid", c_rvalid, 1'b0);
        chk("reset_d_rvalid", d_rvalid, 1'b0);
        chk("reset_c_rdata", c_rdata, 64'h0);
        chk("reset_d_rdata", d_rdata, 64'h0);
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        rst = 1'b0; init_mem = 1'b0;
        chk_en = 1'b1;

        for (int p = 0; p < 7; p++) begin
            c_rate = cfg[p][0]; d_rate = cfg[p][1]; lock_rate = cfg[p][2]; we_rate = cfg[p][3];
            repeat (60) step(1'b1);
            drain();
        end

        // Reset one cycle into an outstanding core read.
        lock_rate = 0;
        c_pend = 1'b1; c_we_v = 1'b0; c_addr_v = 64'h10;
        step(1'b0);
        @(posedge clk);
        cyc++;
        #1;
        chk_en = 1'b0;
        rst = 1'b1; c_req = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_c_rvalid", c_rvalid, 1'b0);
        chk("rst_mid_mem_addr", mem_addr, 64'h0);
        gq.delete(); rq.delete();
        m_free = 0; m_last = 1'b1; m_burst = 0; exp_busy = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        c_pend = 1'b1; c_we_v = 1'b0; c_addr_v = 64'h10;
        c_rate = 50; d_rate = 50; lock_rate = 40; we_rate = 50;
        repeat (40) step(1'b1);
        drain();

        chk("gq_empty", 64'(gq.size()), 64'h0);
        chk("rq_empty", 64'(rq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
